// File: rtl/ir_pkg.sv
// ir_pkg -- shared constants for the instruction fetch queue.
//   ST_IDLE / ST_LOAD / ST_EXEC : one-hot state encodings (also driven on o_state)
//   SET_OPCODE_DEF              : default opcode that marks the next word as immediate data
//   IR_NOP_BIT                  : fill bit of the NOP word (NOP = IR_NOP_BIT replicated, all zeros)
package ir_pkg;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_LOAD = 3'b010;
  localparam logic [2:0] ST_EXEC = 3'b100;

  localparam logic [7:0] SET_OPCODE_DEF = 8'hF0;

  // NOP is defined bitwise so it scales to any instruction width.
  localparam logic IR_NOP_BIT = 1'b0;

endpackage

// File: rtl/ir_queue_mem.sv
// ir_queue_mem -- block-loaded instruction storage with a combinational read mux.
//   clk, rst_n  : clock, synchronous active-low reset (clears every word to NOP)
//   i_wr_en     : write the whole block in one cycle
//   i_wr_block  : DEPTH words, word k at bits [k*IR_WIDTH +: IR_WIDTH]
//   i_rd_idx    : read index
//   o_rd_word   : word at i_rd_idx (combinational)
module ir_queue_mem
  import ir_pkg::*;
#(
  parameter int IR_WIDTH = 8,
  parameter int DEPTH    = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_wr_en,
  input  logic [DEPTH*IR_WIDTH-1:0] i_wr_block,
  input  logic [AW-1:0]             i_rd_idx,
  output logic [IR_WIDTH-1:0]       o_rd_word
);

  logic [IR_WIDTH-1:0] r_mem [DEPTH];

  // Whole-block write; reset fills the queue with NOPs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= {IR_WIDTH{IR_NOP_BIT}};
      end
    end else if (i_wr_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= i_wr_block[k*IR_WIDTH +: IR_WIDTH];
      end
    end
  end

  assign o_rd_word = r_mem[i_rd_idx];

endmodule

// File: rtl/ir_fetch_queue.sv
// ir_fetch_queue -- loads a block of DEPTH instruction words and issues them in order.
// A SET_OPCODE head word is swallowed and turns the following word into immediate
// data, which is presented on o_data with a one-cycle o_data_valid pulse.
//   clk, rst_n            : clock, synchronous active-low reset
//   ld_valid/ld_ready     : block load handshake, ld_block carries DEPTH words (word 0 first)
//   o_ir/o_ir_valid       : queue head and issue qualifier; i_ir_ready accepts it
//   o_data/o_data_valid   : registered immediate data and its one-cycle pulse
//   i_jump/i_stop/i_start : flush-and-reload, halt to IDLE, leave IDLE
//   o_state               : one-hot state IDLE=001, LOAD=010, EXEC=100
module ir_fetch_queue
  import ir_pkg::*;
#(
  parameter int IR_WIDTH                  = 8,
  parameter int DATA_WIDTH                = 8,
  parameter int DEPTH                     = 8,
  parameter logic [IR_WIDTH-1:0] SET_OPCODE = IR_WIDTH'(SET_OPCODE_DEF)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_valid,
  input  logic [DEPTH*IR_WIDTH-1:0] ld_block,
  output logic                      ld_ready,
  output logic [IR_WIDTH-1:0]       o_ir,
  output logic                      o_ir_valid,
  input  logic                      i_ir_ready,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_data_valid,
  input  logic                      i_jump,
  input  logic                      i_stop,
  input  logic                      i_start,
  output logic [2:0]                o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_END = PW'(DEPTH);

  logic [2:0]            r_state;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_pending;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_data_valid;

  logic [IR_WIDTH-1:0]   w_head;
  logic                  w_load_hs;
  logic                  w_at_end;
  logic                  w_head_is_set;
  logic                  w_hold;

  // A stop in the same cycle discards the offered block.
  assign w_load_hs     = (r_state == ST_LOAD) && ld_valid && !i_stop;
  // rd_ptr never goes past DEPTH, so equality means the block is exhausted.
  assign w_at_end      = (r_rd_ptr == PTR_END);
  assign w_head_is_set = (w_head == SET_OPCODE);
  // Jump or stop suppress this cycle's issue, so valid is dropped to keep
  // the consumer from seeing a handshake that does not advance the queue.
  assign w_hold        = i_jump || i_stop || w_at_end;

  ir_queue_mem #(
    .IR_WIDTH (IR_WIDTH),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_load_hs),
    .i_wr_block (ld_block),
    .i_rd_idx   (r_rd_ptr[AW-1:0]),
    .o_rd_word  (w_head)
  );

  assign o_ir         = w_head;
  assign o_ir_valid   = (r_state == ST_EXEC) && !w_hold && !r_pending && !w_head_is_set;
  assign ld_ready     = (r_state == ST_LOAD);
  assign o_state      = r_state;
  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;

  // State machine, read pointer, pending-data flag and immediate data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_LOAD;
      r_rd_ptr     <= {PW{1'b0}};
      r_pending    <= 1'b0;
      r_data       <= {DATA_WIDTH{1'b0}};
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
          end else if (ld_valid) begin
            // pending survives the reload: word 0 may be the data word
            r_rd_ptr <= {PW{1'b0}};
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (i_jump) begin
            r_rd_ptr  <= {PW{1'b0}};
            r_pending <= 1'b0;
            r_state   <= ST_LOAD;
          end else if (i_stop) begin
            r_state <= ST_IDLE;
          end else if (w_at_end) begin
            r_state <= ST_LOAD;
          end else if (r_pending) begin
            // checked before SET so a second SET opcode is taken as data
            r_data       <= w_head[DATA_WIDTH-1:0];
            r_data_valid <= 1'b1;
            r_pending    <= 1'b0;
            r_rd_ptr     <= r_rd_ptr + PW'(1);
          end else if (w_head_is_set) begin
            r_pending <= 1'b1;
            r_rd_ptr  <= r_rd_ptr + PW'(1);
          end else if (i_ir_ready) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_queue.sv
module tb_ir_fetch_queue;

  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_valid = 1'b0;
  logic [DEPTH*W-1:0] ld_block = '0;
  logic             i_ir_ready = 1'b0;
  logic             i_jump = 1'b0;
  logic             i_stop = 1'b0;
  logic             i_start = 1'b0;
  logic             ld_ready, o_ir_valid, o_data_valid;
  logic [W-1:0]     o_ir, o_data;
  logic [2:0]       o_state;

  always #5 clk = ~clk;

  ir_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_block(ld_block), .ld_ready(ld_ready),
    .o_ir(o_ir), .o_ir_valid(o_ir_valid), .i_ir_ready(i_ir_ready),
    .o_data(o_data), .o_data_valid(o_data_valid),
    .i_jump(i_jump), .i_stop(i_stop), .i_start(i_start), .o_state(o_state)
  );

  // Behavioural model: mode 0 = idle, 1 = load, 2 = exec.
  int         m_mode = 1;
  int         m_ptr = 0;
  bit         m_pend = 1'b0;
  logic [7:0] m_q [DEPTH];
  logic [7:0] m_data = 8'h00;
  bit         m_dv = 1'b0;
  bit         m_init = 1'b0;

  int n_vec = 0, n_cmp = 0, n_err = 0;
  logic [7:0] iss_log[$], dat_log[$], exp_iss[$], exp_dat[$];
  logic [2:0] e_state;
  bit         e_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on the active edge, from the inputs the DUT sees on that edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 1; m_ptr = 0; m_pend = 1'b0; m_data = 8'h00; m_dv = 1'b0; m_init = 1'b1;
      for (int k = 0; k < DEPTH; k++) m_q[k] = 8'h00;
    end else begin
      m_dv = 1'b0;
      if (m_mode == 0) begin
        if (i_start) m_mode = 1;
      end else if (m_mode == 1) begin
        if (i_stop) m_mode = 0;
        else if (ld_valid) begin
          for (int k = 0; k < DEPTH; k++) m_q[k] = ld_block[k*W +: W];
          m_ptr = 0; m_mode = 2;
        end
      end else begin
        if (i_jump) begin m_ptr = 0; m_pend = 1'b0; m_mode = 1; end
        else if (i_stop) m_mode = 0;
        else if (m_ptr == DEPTH) m_mode = 1;
        else if (m_pend) begin
          m_data = m_q[m_ptr[2:0]]; m_dv = 1'b1; m_pend = 1'b0; m_ptr++;
        end else if (m_q[m_ptr[2:0]] == 8'hF0) begin
          m_pend = 1'b1; m_ptr++;
        end else if (i_ir_ready) m_ptr++;
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      e_state = 3'b001 << m_mode;
      e_valid = (m_mode == 2) && (m_ptr < DEPTH) && !m_pend && !i_jump && !i_stop
                && (m_q[m_ptr[2:0]] != 8'hF0);
      chk("state", 64'(o_state), 64'(e_state));
      chk("ld_ready", 64'(ld_ready), 64'(m_mode == 1));
      chk("ir_valid", 64'(o_ir_valid), 64'(e_valid));
      if (e_valid) chk("ir", 64'(o_ir), 64'(m_q[m_ptr[2:0]]));
      chk("data", 64'(o_data), 64'(m_data));
      chk("data_valid", 64'(o_data_valid), 64'(m_dv));
      if (o_ir_valid && i_ir_ready) iss_log.push_back(o_ir);
      if (o_data_valid) dat_log.push_back(o_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; n_vec++; end
  endtask

  task automatic wait_load();
    int b = 0;
    while (m_mode != 1 && b < 30) begin tick(1); b++; end
    if (m_mode != 1) begin
      n_err++;
      $display("FAIL wait_load: LOAD not reached within 30 cycles");
    end
  endtask

  task automatic load(input logic [63:0] blk);
    wait_load();
    ld_block = blk; ld_valid = 1'b1;
    tick(1);
    ld_valid = 1'b0;
  endtask

  task automatic exp_seq(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) exp_iss.push_back(first + 8'(k));
  endtask

  task automatic chk_logs(input string name);
    chk({name, " issue count"}, 64'(iss_log.size()), 64'(exp_iss.size()));
    for (int k = 0; k < exp_iss.size() && k < iss_log.size(); k++)
      chk({name, " issued word"}, 64'(iss_log[k]), 64'(exp_iss[k]));
    chk({name, " data count"}, 64'(dat_log.size()), 64'(exp_dat.size()));
    for (int k = 0; k < exp_dat.size() && k < dat_log.size(); k++)
      chk({name, " data word"}, 64'(dat_log[k]), 64'(exp_dat[k]));
    iss_log.delete(); dat_log.delete(); exp_iss.delete(); exp_dat.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(2);
    rst_n = 1'b1;
    chk("reset o_state", 64'(o_state), 64'h2);
    chk("reset ld_ready", 64'(ld_ready), 64'h1);
    chk("reset o_ir_valid", 64'(o_ir_valid), 64'h0);
    chk("reset o_data", 64'(o_data), 64'h0);

    // Straight block 01..08
    i_ir_ready = 1'b1;
    load(64'h08_07_06_05_04_03_02_01);
    tick(12);
    exp_seq(8'h01, 8);
    chk_logs("straight");
    chk("end of block state", 64'(o_state), 64'h2);

    // SET in the middle of a block
    load(64'h06_05_04_03_02_5A_F0_01);
    tick(12);
    exp_iss.push_back(8'h01); exp_seq(8'h02, 5); exp_dat.push_back(8'h5A);
    chk_logs("set_mid");
    chk("set_mid data held", 64'(o_data), 64'h5A);

    // SET in the last word, data word is word 0 of the next block
    load(64'hF0_17_16_15_14_13_12_11);
    load(64'h27_26_25_24_23_22_21_3C);
    chk("reload pending ir_valid", 64'(o_ir_valid), 64'h0);
    tick(1);
    chk("reload o_data_valid", 64'(o_data_valid), 64'h1);
    chk("reload o_data", 64'(o_data), 64'h3C);
    chk("reload o_ir", 64'(o_ir), 64'h21);
    chk("reload o_ir_valid", 64'(o_ir_valid), 64'h1);
    tick(12);
    exp_seq(8'h11, 7); exp_seq(8'h21, 7); exp_dat.push_back(8'h3C);
    chk_logs("set_last");

    // Jump and stop together at rd_ptr = 3
    load(64'h08_07_06_05_04_03_02_01);
    tick(3);
    i_jump = 1'b1; i_stop = 1'b1;
    #1;
    chk("jump ir_valid", 64'(o_ir_valid), 64'h0);
    tick(1);
    i_jump = 1'b0; i_stop = 1'b0;
    chk("jump next state", 64'(o_state), 64'h2);
    load(64'h48_47_46_45_44_43_42_41);
    tick(12);
    exp_seq(8'h01, 3); exp_seq(8'h41, 8);
    chk_logs("jump");

    // Stop at rd_ptr = 4, restart, new block
    load(64'h08_07_06_05_04_03_02_01);
    tick(4);
    i_stop = 1'b1; tick(1); i_stop = 1'b0;
    chk("stop state", 64'(o_state), 64'h1);
    tick(2);
    i_start = 1'b1; tick(1); i_start = 1'b0;
    chk("start state", 64'(o_state), 64'h2);
    load(64'h58_57_56_55_54_53_52_51);
    tick(12);
    exp_seq(8'h01, 4); exp_seq(8'h51, 8);
    chk_logs("stop_start");

    // Consumer back-pressure for 5 cycles
    i_ir_ready = 1'b0;
    load(64'h68_67_66_65_64_63_62_61);
    tick(5);
    chk("stall o_ir", 64'(o_ir), 64'h61);
    chk("stall o_ir_valid", 64'(o_ir_valid), 64'h1);
    i_ir_ready = 1'b1;
    tick(12);
    exp_seq(8'h61, 8);
    chk_logs("stall");

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      ld_valid   = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < DEPTH; k++)
        ld_block[k*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
      i_ir_ready = ($urandom_range(0, 9) < 7);
      i_jump     = ($urandom_range(0, 19) == 0);
      i_stop     = ($urandom_range(0, 19) == 0);
      i_start    = ($urandom_range(0, 2) == 0);
      tick(1);
    end
    iss_log.delete(); dat_log.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ir_fetch_queue.md
IR_FETCH_QUEUE -- requirements
Module: ir_fetch_queue

Interface
REQ-001 The block SHALL have parameter IR_WIDTH, default 8, instruction word width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, immediate data width in bits (DATA_WIDTH <= IR_WIDTH; the low bits are used).
REQ-003 The block SHALL have parameter DEPTH, default 8, number of instruction words per loaded block (power of two, 2..64).
REQ-004 The block SHALL have parameter SET_OPCODE, default 8'hF0, opcode marking the next word as immediate data.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 ld_valid  input  1  instruction block present on ld_block.
REQ-008 ld_block  input  DEPTH*IR_WIDTH  block; word k occupies bits [k*IR_WIDTH +: IR_WIDTH]; word 0 executes first.
REQ-009 ld_ready  output  1  block accepted when ld_valid and ld_ready are both high.
REQ-010 o_ir  output  IR_WIDTH  instruction at the queue head.
REQ-011 o_ir_valid  output  1  o_ir is issuable.
REQ-012 i_ir_ready  input  1  consumer accepts o_ir; issue = o_ir_valid and i_ir_ready.
REQ-013 o_data  output  DATA_WIDTH  registered immediate data.
REQ-014 o_data_valid  output  1  one-cycle pulse qualifying o_data.
REQ-015 i_jump  input  1  flush the queue and reload.
REQ-016 i_stop  input  1  halt into IDLE.
REQ-017 i_start  input  1  leave IDLE.
REQ-018 o_state  output  3  one-hot state: IDLE=001, LOAD=010, EXEC=100.

Function
REQ-019 States SHALL be IDLE, LOAD and EXEC; ld_ready SHALL equal (state==LOAD).
REQ-020 LOAD: on a handshake the block SHALL write all DEPTH words, set rd_ptr=0 and enter EXEC on the next cycle.
REQ-021 EXEC: o_ir SHALL equal queue[rd_ptr] combinationally; o_ir_valid SHALL be high iff rd_ptr<DEPTH, the head is not SET_OPCODE and no data word is pending.
REQ-022 Each issue SHALL increment rd_ptr by 1 (counter width clog2(DEPTH)+1, no wrap).
REQ-023 A head equal to SET_OPCODE SHALL be consumed in one cycle without i_ir_ready and SHALL set the pending flag; it SHALL never appear with o_ir_valid high.
REQ-024 With the pending flag set, the next head word SHALL be consumed in one cycle; o_data SHALL take its low DATA_WIDTH bits and o_data_valid SHALL pulse on the following cycle; the pending flag SHALL then clear.
REQ-025 Two consecutive SET_OPCODE words SHALL make the second one data, not a new SET.
REQ-026 When rd_ptr reaches DEPTH, the state SHALL go to LOAD on the next cycle.
REQ-027 The pending flag SHALL survive an end-of-block reload, so that word 0 of the next block becomes the data word.
REQ-028 In EXEC, i_jump SHALL take priority over i_stop, end-of-block and issue: the cycle's issue SHALL be suppressed, the pending flag cleared, rd_ptr zeroed, and the next state SHALL be LOAD.
REQ-029 In EXEC, i_stop without i_jump SHALL suppress the issue and enter IDLE; queue, rd_ptr and pending flag SHALL be retained.
REQ-030 In IDLE, i_start SHALL enter LOAD; i_jump and i_stop SHALL be ignored.
REQ-031 In LOAD, i_jump SHALL be ignored and i_stop SHALL enter IDLE, discarding a same-cycle ld_valid.
REQ-032 An illegal state encoding SHALL recover to IDLE.

Reset
REQ-033 With rst_n low at a clock edge, state SHALL become LOAD, rd_ptr 0, the pending flag 0, all queue words 0, o_data 0 and o_data_valid 0; o_ir_valid SHALL be 0 and ld_ready SHALL be 1 from the first cycle after reset.
REQ-034 Reset asserted mid-block or mid-SET SHALL take effect on the same edge, overriding every other input.

Structure
REQ-035 The state encodings, SET_OPCODE default and the NOP value (all zeros) SHALL live in the shared package ir_pkg.
REQ-036 The queue storage and its read mux SHALL be one sub-module, ir_queue_mem (parameters IR_WIDTH, DEPTH).

Verification
REQ-037 Reset, load block 01..08, i_ir_ready=1 -> o_ir 01..08 issued on 8 consecutive cycles after EXEC entry, then LOAD.
REQ-038 Block {01,F0,5A,02,...} -> 01 issued, no issue for two cycles, o_data=5A with one o_data_valid pulse, then 02 issued.
REQ-039 F0 in word 7, next block starts with 3C -> o_data=3C after the reload, and word 1 of the new block is the next o_ir.
REQ-040 i_jump and i_stop together at rd_ptr=3 -> no issue, LOAD next cycle, reloaded block starts at word 0.
REQ-041 i_stop at rd_ptr=4, then i_start, then a new block -> IDLE, LOAD, execution restarts at word 0 of the new block.
REQ-042 i_ir_ready held low for 5 cycles -> o_ir stable with o_ir_valid high, and rd_ptr unchanged.
